// File: rtl/tbox_auto_player_if.sv
// rtl/tbox_auto_player_if.sv - TBox board bus plus human move request/ack handshake
interface tbox_auto_player_if;
  logic       set;
  logic [1:0] row;
  logic [1:0] col;
  logic [8:0] valid;
  logic [8:0] symbol;
  logic [1:0] game_state;
  logic       human_req;
  logic [1:0] human_row;
  logic [1:0] human_col;
  logic       human_ack;
  logic       human_rej;

  modport master (
    output set, row, col, human_ack, human_rej,
    input  valid, symbol, game_state, human_req, human_row, human_col
  );

  modport slave (
    input  set, row, col, human_ack, human_rej,
    output valid, symbol, game_state, human_req, human_row, human_col
  );
endinterface

// File: rtl/tbox_auto_player.sv
// rtl/tbox_auto_player.sv - TBox move issuer: CPU priority search (win/block/center/corner/edge) and human move forwarding
module tbox_auto_player (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   cpu_is_x,
  output logic                   busy,
  tbox_auto_player_if.master     bus
);

  typedef enum logic [2:0] {IDLE, SCAN_WIN, SCAN_BLK, PICK, ISSUE, SETTLE} state_t;

  localparam logic [3:0] PICK_ORDER [9] = '{4'd4, 4'd0, 4'd2, 4'd6, 4'd8, 4'd1, 4'd3, 4'd5, 4'd7};

  function automatic logic [11:0] line_cells(input logic [2:0] l);
    case (l)
      3'd0:    line_cells = {4'd2, 4'd1, 4'd0};
      3'd1:    line_cells = {4'd5, 4'd4, 4'd3};
      3'd2:    line_cells = {4'd8, 4'd7, 4'd6};
      3'd3:    line_cells = {4'd6, 4'd3, 4'd0};
      3'd4:    line_cells = {4'd7, 4'd4, 4'd1};
      3'd5:    line_cells = {4'd8, 4'd5, 4'd2};
      3'd6:    line_cells = {4'd8, 4'd4, 4'd0};
      default: line_cells = {4'd6, 4'd4, 4'd2};
    endcase
  endfunction

  function automatic logic [3:0] cell_rc(input logic [3:0] c);
    case (c)
      4'd0:    cell_rc = {2'b01, 2'b01};
      4'd1:    cell_rc = {2'b01, 2'b10};
      4'd2:    cell_rc = {2'b01, 2'b11};
      4'd3:    cell_rc = {2'b10, 2'b01};
      4'd4:    cell_rc = {2'b10, 2'b10};
      4'd5:    cell_rc = {2'b10, 2'b11};
      4'd6:    cell_rc = {2'b11, 2'b01};
      4'd7:    cell_rc = {2'b11, 2'b10};
      default: cell_rc = {2'b11, 2'b11};
    endcase
  endfunction

  state_t     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [3:0] cell_q, cell_d;
  logic [8:0] snap_v_q, snap_v_d;
  logic [8:0] snap_s_q, snap_s_d;
  logic       human_q, human_d;
  logic       set_q, set_d;
  logic [1:0] row_q, row_d;
  logic [1:0] col_q, col_d;
  logic       ack_q, ack_d;
  logic       rej_q, rej_d;
  logic       busy_q, busy_d;

  logic [8:0]  own_mask, scan_mask;
  logic [11:0] lc;
  logic [3:0]  c0, c1, c2, hit_cell, pick_cell, hr_cell;
  logic [1:0]  n_mark, n_empty;
  logic        hit, changed, cpu_turn, hr_bad;

  assign own_mask  = snap_v_q & (cpu_is_x ? snap_s_q : ~snap_s_q);
  assign scan_mask = (state_q == SCAN_WIN) ? own_mask : (snap_v_q & ~own_mask);
  assign lc        = line_cells(idx_q);
  assign c0        = lc[3:0];
  assign c1        = lc[7:4];
  assign c2        = lc[11:8];
  assign n_mark    = {1'b0, scan_mask[c0]} + {1'b0, scan_mask[c1]} + {1'b0, scan_mask[c2]};
  assign n_empty   = {1'b0, ~snap_v_q[c0]} + {1'b0, ~snap_v_q[c1]} + {1'b0, ~snap_v_q[c2]};
  assign hit       = (n_mark == 2'd2) && (n_empty == 2'd1);
  assign hit_cell  = !snap_v_q[c0] ? c0 : (!snap_v_q[c1] ? c1 : c2);
  assign changed   = (bus.valid != snap_v_q) || (bus.symbol != snap_s_q) || (bus.game_state != 2'b00);
  // X moves on an even number of occupied cells
  assign cpu_turn  = (~(^bus.valid)) == cpu_is_x;
  assign hr_bad    = (bus.human_row == 2'b00) || (bus.human_col == 2'b00);
  assign hr_cell   = 4'd3 * ({2'b00, bus.human_row} - 4'd1) + ({2'b00, bus.human_col} - 4'd1);

  always_comb begin
    pick_cell = 4'd0;
    for (int i = 8; i >= 0; i--) begin
      if (!snap_v_q[PICK_ORDER[i]]) pick_cell = PICK_ORDER[i];
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cell_d   = cell_q;
    snap_v_d = snap_v_q;
    snap_s_d = snap_s_q;
    human_d  = human_q;
    set_d    = 1'b0;
    row_d    = 2'b00;
    col_d    = 2'b00;
    ack_d    = 1'b0;
    rej_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.game_state != 2'b00) begin
          rej_d = bus.human_req && !rej_q;
        end else if (cpu_turn) begin
          rej_d = bus.human_req && !rej_q;
          if (enable) begin
            snap_v_d = bus.valid;
            snap_s_d = bus.symbol;
            idx_d    = 3'd0;
            state_d  = SCAN_WIN;
          end
        end else if (bus.human_req) begin
          if (hr_bad || bus.valid[hr_cell]) begin
            rej_d = !rej_q;
          end else begin
            cell_d  = hr_cell;
            human_d = 1'b1;
            state_d = ISSUE;
          end
        end
      end
      SCAN_WIN, SCAN_BLK: begin
        if (changed) begin
          state_d = IDLE;
        end else if (hit) begin
          cell_d  = hit_cell;
          human_d = 1'b0;
          state_d = ISSUE;
        end else if (idx_q == 3'd7) begin
          idx_d   = 3'd0;
          state_d = (state_q == SCAN_WIN) ? SCAN_BLK : PICK;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      PICK: begin
        if (changed) begin
          state_d = IDLE;
        end else begin
          cell_d  = pick_cell;
          human_d = 1'b0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        set_d          = 1'b1;
        {row_d, col_d} = cell_rc(cell_q);
        ack_d          = human_q;
        state_d        = SETTLE;
      end
      default: begin
        human_d = 1'b0;
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= 3'd0;
      cell_q   <= 4'd0;
      snap_v_q <= 9'd0;
      snap_s_q <= 9'd0;
      human_q  <= 1'b0;
      set_q    <= 1'b0;
      row_q    <= 2'b00;
      col_q    <= 2'b00;
      ack_q    <= 1'b0;
      rej_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cell_q   <= cell_d;
      snap_v_q <= snap_v_d;
      snap_s_q <= snap_s_d;
      human_q  <= human_d;
      set_q    <= set_d;
      row_q    <= row_d;
      col_q    <= col_d;
      ack_q    <= ack_d;
      rej_q    <= rej_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.set       = set_q;
  assign bus.row       = row_q;
  assign bus.col       = col_q;
  assign bus.human_ack = ack_q;
  assign bus.human_rej = rej_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_tbox_auto_player.sv
// tb/tb_tbox_auto_player.sv - directed bench for tbox_auto_player with a behavioural TBox board
module tb_tbox_auto_player;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic cpu_is_x = 1'b1;
  logic busy;
  logic human_req = 1'b0;
  logic [1:0] human_row = 2'b00;
  logic [1:0] human_col = 2'b00;
  logic [8:0] tb_valid, tb_symbol, load_v, load_s;
  logic load_en = 1'b0;
  logic [1:0] tb_gs;
  int errors = 0;
  int checks = 0;
  int n_sets = 0;

  always #5 clk = ~clk;

  tbox_auto_player_if bus ();

  assign bus.valid      = tb_valid;
  assign bus.symbol     = tb_symbol;
  assign bus.game_state = tb_gs;
  assign bus.human_req  = human_req;
  assign bus.human_row  = human_row;
  assign bus.human_col  = human_col;

  tbox_auto_player dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .cpu_is_x (cpu_is_x),
    .busy     (busy),
    .bus      (bus.master)
  );

  function automatic logic [1:0] gs_of(input logic [8:0] v, input logic [8:0] s);
    int ln [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6}, '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
    gs_of = (v == 9'h1ff) ? 2'b11 : 2'b00;
    for (int i = 0; i < 8; i++) begin
      if (v[ln[i][0]] && v[ln[i][1]] && v[ln[i][2]]) begin
        if (s[ln[i][0]] && s[ln[i][1]] && s[ln[i][2]]) return 2'b01;
        if (!s[ln[i][0]] && !s[ln[i][1]] && !s[ln[i][2]]) return 2'b10;
      end
    end
  endfunction

  assign tb_gs = gs_of(tb_valid, tb_symbol);

  always @(posedge clk or posedge reset) begin
    int k;
    if (reset) begin
      tb_valid  <= 9'd0;
      tb_symbol <= 9'd0;
    end else if (load_en) begin
      tb_valid  <= load_v;
      tb_symbol <= load_s;
    end else if (bus.set && bus.row != 2'b00 && bus.col != 2'b00) begin
      k = (int'(bus.row) - 1) * 3 + (int'(bus.col) - 1);
      tb_valid[k]  <= 1'b1;
      tb_symbol[k] <= ~(^tb_valid);
    end
  end

  always @(negedge clk) if (bus.set) n_sets <= n_sets + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic load_board(input logic [8:0] v, input logic [8:0] s);
    @(negedge clk);
    load_v  = v;
    load_s  = s;
    load_en = 1'b1;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  // Called at a negedge: cycle 1 is the next posedge (the decision edge).
  task automatic wait_set(output int lat, output int r, output int c, output int a);
    lat = -1; r = -1; c = -1; a = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.set) begin
        lat = i - 1; r = int'(bus.row); c = int'(bus.col); a = int'(bus.human_ack);
        break;
      end
    end
  endtask

  task automatic wait_resp(output int cyc, output int ack, output int rej);
    cyc = -1; ack = 0; rej = 0;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.human_ack || bus.human_rej) begin
        cyc = i; ack = int'(bus.human_ack); rej = int'(bus.human_rej);
        break;
      end
    end
  endtask

  typedef struct {
    logic [8:0] v;
    logic [8:0] s;
    logic       cx;
    int         lat;
    int         r;
    int         c;
    int         gs;
  } vec_t;

  initial begin
    vec_t vecs [6];
    int lat, r, c, a, cyc, ack, rej, s0, bsy_seen;

    vecs[0] = '{9'h000, 9'h000, 1'b1, 18, 2, 2, 0};
    vecs[1] = '{9'h093, 9'h003, 1'b1,  2, 1, 3, 1};
    vecs[2] = '{9'h015, 9'h011, 1'b0, 16, 3, 3, 0};
    vecs[3] = '{9'h010, 9'h010, 1'b0, 18, 1, 1, 0};
    vecs[4] = '{9'h017, 9'h014, 1'b1,  9, 3, 1, 1};
    vecs[5] = '{9'h113, 9'h110, 1'b1, 10, 1, 3, 0};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_set", int'(bus.set), 0);
    check("reset_row", int'(bus.row), 0);
    check("reset_col", int'(bus.col), 0);
    check("reset_ack", int'(bus.human_ack), 0);
    check("reset_rej", int'(bus.human_rej), 0);
    check("reset_busy", int'(busy), 0);

    for (int i = 0; i < 6; i++) begin
      enable   = 1'b0;
      cpu_is_x = vecs[i].cx;
      load_board(vecs[i].v, vecs[i].s);
      @(negedge clk);
      s0     = n_sets;
      enable = 1'b1;
      wait_set(lat, r, c, a);
      enable = 1'b0;
      check($sformatf("v%0d_row_idle", i), int'(bus.row == 2'b00 || bus.set), 1);
      repeat (4) @(negedge clk);
      check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("v%0d_row", i), r, vecs[i].r);
      check($sformatf("v%0d_col", i), c, vecs[i].c);
      check($sformatf("v%0d_nsets", i), n_sets - s0, 1);
      check($sformatf("v%0d_busy", i), int'(busy), 0);
      check($sformatf("v%0d_row_after", i), int'(bus.row), 0);
      check($sformatf("v%0d_game_state", i), int'(tb_gs), vecs[i].gs);
    end

    // Human plays O against CPU X; X already on the centre.
    cpu_is_x = 1'b1;
    enable   = 1'b1;
    load_board(9'h010, 9'h010);
    s0 = n_sets;
    human_req = 1'b1; human_row = 2'b10; human_col = 2'b10;
    wait_resp(cyc, ack, rej);
    human_req = 1'b0;
    check("hum_occ_rej", rej, 1);
    check("hum_occ_ack", ack, 0);
    check("hum_occ_cyc", cyc, 1);
    @(negedge clk);
    human_req = 1'b1; human_row = 2'b00; human_col = 2'b01;
    wait_resp(cyc, ack, rej);
    human_req = 1'b0;
    check("hum_bad_rej", rej, 1);
    @(negedge clk);
    check("hum_rej_nosets", n_sets - s0, 0);
    enable = 1'b0;
    human_req = 1'b1; human_row = 2'b01; human_col = 2'b01;
    wait_set(lat, r, c, a);
    human_req = 1'b0;
    check("hum_ok_latency", lat, 1);
    check("hum_ok_ack", a, 1);
    check("hum_ok_row", r, 1);
    check("hum_ok_col", c, 1);
    repeat (2) @(negedge clk);
    check("hum_ok_board", int'({tb_valid[0], tb_symbol[0]}), 2);
    check("hum_ok_nsets", n_sets - s0, 1);

    // Now X's turn: a human request is out of turn.
    human_req = 1'b1; human_row = 2'b11; human_col = 2'b11;
    wait_resp(cyc, ack, rej);
    human_req = 1'b0;
    check("hum_turn_rej", rej, 1);

    // Game over: X has the top row.
    enable = 1'b1;
    load_board(9'h01f, 9'h007);
    s0 = n_sets;
    human_req = 1'b1; human_row = 2'b11; human_col = 2'b11;
    wait_resp(cyc, ack, rej);
    human_req = 1'b0;
    check("over_rej", rej, 1);
    check("over_ack", ack, 0);
    bsy_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (busy) bsy_seen = 1;
    end
    check("over_nosets", n_sets - s0, 0);
    check("over_busy", bsy_seen, 0);

    // Board cleared while the CPU is in its block scan.
    enable = 1'b0;
    cpu_is_x = 1'b1;
    load_board(9'h011, 9'h010);
    @(negedge clk);
    s0 = n_sets;
    enable = 1'b1;
    repeat (11) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("abort_busy_pre", int'(busy), 1);
    load_board(9'h000, 9'h000);
    cyc = -1;
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (!busy) begin
        cyc = i;
        break;
      end
    end
    check("abort_busy_drop", int'(cyc > 0), 1);
    check("abort_nosets", n_sets - s0, 0);
    wait_set(lat, r, c, a);
    check("abort_restart_lat", lat, 18);
    check("abort_restart_row", r, 2);
    check("abort_restart_col", c, 2);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_total_sets", n_sets - s0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
